ex_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the execute-stage ALU. It accepts one operation at a time from the execute stage and raises `busy` so the pipeline stalls while it runs. It runs a pipelined multiplier, an iterative radix-2 divider and multiply-accumulate, and pulses `done` when HI/LO hold the new result. HI/LO are owned here; the ALU reads them through `hi`/`lo` for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_div_radix2.sv | 52 +++++
 rtl/ex_muldiv.sv | 136 +++++++++++++
 tb/tb_ex_muldiv.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the execute-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MADD  = 4'd4,
    MADDU = 4'd5,
    MSUB  = 4'd6,
    MSUBU = 4'd7,
    MTHI  = 4'd8,
    MTLO  = 4'd9
  } muldiv_op_t;

  // S_ prefix keeps state literals clear of the DIV op literal.
  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DIV_FIX
  } muldiv_state_t;

  function automatic logic is_signed(muldiv_op_t op);
    return op inside {MULT, DIV, MADD, MSUB};
  endfunction

  function automatic logic is_accum(muldiv_op_t op);
    return op inside {MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_mul(muldiv_op_t op);
    return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_div(muldiv_op_t op);
    return op inside {DIV, DIVU};
  endfunction

endpackage

// File: rtl/muldiv_div_radix2.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH iterations after start.
module muldiv_div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // quotient doubles as the dividend shift register during iteration
  assign shifted = {remainder, quotient[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvsr};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      run   <= 1'b0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        remainder <= '0;
        quotient  <= dividend;
        dvsr      <= divisor;
        cnt       <= CW'(WIDTH);
        run       <= 1'b1;
      end else if (run) begin
        remainder <= ge ? WIDTH'(shifted - {1'b0, dvsr}) : shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], ge};
        cnt       <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run   <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide/MAC unit owning the architectural HI/LO registers.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PW      = 2 * WIDTH;

  muldiv_state_t    state;
  logic [CNT_W-1:0] cnt;
  muldiv_op_t       op_q;
  logic [PW-1:0]    opa_q, opb_q;
  logic             q_neg, r_neg;

  logic             accept, sgn, a_neg, b_neg, div_start, div_valid;
  logic [WIDTH-1:0] a_mag, b_mag, div_q, div_r;
  logic [PW-1:0]    acc, mul_res;
  logic [PW-1:0]    prod_pipe [MUL_STAGES];

  assign accept    = (state == S_IDLE) && op_valid && !flush;
  assign sgn       = is_signed(op);
  assign a_neg     = sgn & src_a[WIDTH-1];
  assign b_neg     = sgn & src_b[WIDTH-1];
  assign a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
  assign b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
  assign div_start = accept && is_div(op) && (src_b != '0);

  // Operands are pre-extended to 2*WIDTH, so a plain product truncated to
  // 2*WIDTH bits is correct for both signed and unsigned variants.
  assign prod_pipe[0] = opa_q * opb_q;
  for (genvar k = 1; k < MUL_STAGES; k++) begin : g_mul
    always_ff @(posedge clk) prod_pipe[k] <= prod_pipe[k-1];
  end

  always_comb begin
    acc = {hi, lo};
    if (op_q inside {MSUB, MSUBU})
      mul_res = acc - prod_pipe[MUL_STAGES-1];
    else if (is_accum(op_q))
      mul_res = acc + prod_pipe[MUL_STAGES-1];
    else
      mul_res = prod_pipe[MUL_STAGES-1];
  end

  muldiv_div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (div_start),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (div_q),
    .remainder(div_r),
    .valid    (div_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          op_q <= op;
          if (op == MTHI) hi <= src_a;
          else if (op == MTLO) lo <= src_a;
          else if (is_div(op)) begin
            if (src_b == '0) done <= 1'b1;
            else begin
              state <= S_DIV;
              cnt   <= CNT_W'(WIDTH);
              busy  <= 1'b1;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
            end
          end else if (is_mul(op)) begin
            state <= S_MUL;
            cnt   <= CNT_W'(MUL_STAGES);
            busy  <= 1'b1;
            opa_q <= {{WIDTH{a_neg}}, src_a};
            opb_q <= {{WIDTH{b_neg}}, src_b};
          end
        end
        S_MUL: if (flush) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else if (cnt == CNT_W'(1)) begin
          {hi, lo} <= mul_res;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end else cnt <= cnt - CNT_W'(1);
        S_DIV: if (flush) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else if (cnt == CNT_W'(1)) state <= S_DIV_FIX;
        else cnt <= cnt - CNT_W'(1);
        S_DIV_FIX: if (flush) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else if (div_valid) begin
          lo    <= q_neg ? (~div_q + 1'b1) : div_q;
          hi    <= r_neg ? (~div_r + 1'b1) : div_r;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: ordered vector table scored through a done-driven queue, plus flush/reset corners.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  muldiv_op_t  op = MULT;
  logic [31:0] src_a = '0, src_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  ex_muldiv #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t        vecs[16];
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;
  int          n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every done pops the oldest expected {hi,lo}
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        mon_exp = sb_q.pop_front();
        check("sb_result", {hi, lo}, mon_exp);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input vec_t v, input string tag);
    int lat, nbusy, exp_lat;
    bit mt;
    mt      = v.op inside {MTHI, MTLO};
    exp_lat = (v.op inside {DIV, DIVU}) ? ((v.b == 0) ? 1 : 34) : 3;
    if (!mt) sb_q.push_back({v.hi, v.lo});
    op_valid = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
    step(1);
    op_valid = 1'b0;
    if (mt) begin
      check({tag, "_mt_hilo"}, {hi, lo}, {v.hi, v.lo});
      check({tag, "_mt_busy"}, {63'd0, busy}, 64'd0);
      return;
    end
    lat = 1; nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      step(1);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
    check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    bit saw_done;
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'h00000001};
    vecs[3]  = '{MTLO,  32'hFFFFFFFF, 32'd0,        32'h12345678, 32'hFFFFFFFF};
    vecs[4]  = '{MADDU, 32'd1,        32'd1,        32'h12345679, 32'h00000000};
    vecs[5]  = '{MSUB,  32'd1,        32'd1,        32'h12345678, 32'hFFFFFFFF};
    vecs[6]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[8]  = '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[9]  = '{DIVU,  32'd5,        32'd0,        32'h00000002, 32'h0000000E};
    vecs[10] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{MSUBU, 32'd2,        32'd3,        32'h00000001, 32'hFFFFFFF7};
    vecs[12] = '{MADD,  32'hFFFFFFFF, 32'd3,        32'h00000001, 32'hFFFFFFF4};
    vecs[13] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[14] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    vecs[15] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

    step(2);
    rst = 1'b0;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);

    // issue returns in the done cycle, so consecutive vectors run back-to-back
    for (int i = 0; i < 16; i++) issue(vecs[i], $sformatf("vec%0d", i));

    // op_valid while busy must be ignored
    sb_q.push_back({32'd0, 32'd15});
    op_valid = 1'b1; op = MULT; src_a = 32'd3; src_b = 32'd5;
    step(1);
    op = MTHI; src_a = 32'hDEADBEEF;
    step(2);
    op_valid = 1'b0;
    check("busy_ignore_done", {63'd0, done}, 64'd1);
    check("busy_ignore_hilo", {hi, lo}, {32'd0, 32'd15});

    // flush in cycle 5 of a divide
    step(1);
    op_valid = 1'b1; op = DIV; src_a = 32'd100; src_b = 32'd3;
    step(1);
    op_valid = 1'b0;
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("flush_busy_cycle6", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      step(1);
    end
    check("flush_no_done", {63'd0, saw_done}, 64'd0);
    check("flush_hilo_kept", {hi, lo}, {32'd0, 32'd15});

    // reset in cycle 10 of a divide
    op_valid = 1'b1; op = DIVU; src_a = 32'd1000; src_b = 32'd9;
    step(1);
    op_valid = 1'b0;
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    step(3);
    check("midrst_stays_idle", {63'd0, busy}, 64'd0);

    // flush coincident with op_valid in idle: nothing accepted
    op_valid = 1'b1; flush = 1'b1; op = MTHI; src_a = 32'hA5A5A5A5;
    step(1);
    check("idle_flush_mthi", {hi, lo}, 64'd0);
    op = MULT; src_a = 32'd2; src_b = 32'd3;
    step(1);
    op_valid = 1'b0; flush = 1'b0;
    check("idle_flush_mult_busy", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) saw_done = 1'b1;
      step(1);
    end
    check("idle_flush_no_activity", {63'd0, saw_done}, 64'd0);
    op_valid = 1'b1; flush = 1'b1; op = DIVU; src_a = 32'd4; src_b = 32'd0;
    step(1);
    op_valid = 1'b0; flush = 1'b0;
    check("idle_flush_div0_done", {63'd0, done}, 64'd0);
    check("idle_flush_hilo", {hi, lo}, 64'd0);

    step(2);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
